uart_send_queue: RTL

- Transmit-side counterpart of the boot loader and receive ring buffer path.
- The core pushes 32-bit words. The block queues them in a FIFO, splits each word into 4 bytes, and drives the UartTx `tx_start`/`sdata`/`tx_busy` handshake one byte at a time.
- It sits between the core's send request and UartTx, so the core never has to wait on UART byte timing.

---
 rtl/uart_send_queue.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_send_queue.sv
// -----------------------------------------------------------------------------
// uart_send_queue
//
// Transmit-side word queue for the UART path. The core pushes 32-bit words into
// a circular FIFO. A serializer pops one word at a time and hands it to UartTx
// one byte at a time using the tx_start / sdata / tx_busy handshake. The core
// therefore never waits on UART byte timing.
//
// Byte order: little-endian (LSB first) by default. Define the macro
// UART_SEND_BIG_ENDIAN_EN to send MSB first.
//
// Parameters:
//   DEPTH    FIFO capacity in words (power of two, >= 2)
//   SIZE_W   width of the size output
//
// Ports:
//   clock     in   system clock, rising edge
//   resetn    in   asynchronous active-low reset
//   we        in   push wd into the FIFO this cycle
//   wd        in   word to send
//   full      out  FIFO holds DEPTH words
//   size      out  words held in the FIFO (word being serialized not counted)
//   overflow  out  sticky: a push was dropped because the FIFO was full
//   tx_busy   in   UartTx busy
//   tx_start  out  one-cycle request for UartTx to send sdata
//   sdata     out  byte to transmit, valid while tx_start is high
//   idle      out  serializer idle and FIFO empty
// -----------------------------------------------------------------------------
module uart_send_queue #(
  parameter int DEPTH  = 16,
  parameter int SIZE_W = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              we,
  input  logic [31:0]       wd,
  output logic              full,
  output logic [SIZE_W-1:0] size,
  output logic              overflow,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        sdata,
  output logic              idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [SIZE_W-1:0] SZ_ZERO  = SIZE_W'(0);
  localparam logic [SIZE_W-1:0] SZ_ONE   = SIZE_W'(1);
  localparam logic [SIZE_W-1:0] DEPTH_SZ = SIZE_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_GUARD = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  // Select byte k of a word in the configured transmit order.
  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] k);
    logic [7:0] b;
    case (k)
`ifdef UART_SEND_BIG_ENDIAN_EN
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      2'd3:    b = word[7:0];
      default: b = 8'h00;
`else
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
`endif
    endcase
    return b;
  endfunction

  logic [31:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic              overflow_q, overflow_d;

  state_e            state_q;
  logic [31:0]       word_q;
  logic [1:0]        k_q;
  logic              tx_start_q;
  logic [7:0]        sdata_q;

  logic              full_s;
  logic              push_s;
  logic              pop_s;

  // full is judged on the registered size, so a same-cycle pop cannot rescue a push.
  assign full_s = (size_q == DEPTH_SZ);
  assign push_s = we && !full_s;
  assign pop_s  = (state_q == ST_IDLE) && (size_q != SZ_ZERO);

  // FIFO pointer, occupancy and overflow next-state.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    size_d     = size_q;
    overflow_d = overflow_q;
    // Pointers are PTR_W bits wide, so the increment wraps DEPTH-1 -> 0.
    if (push_s) begin
      tail_d = tail_q + PTR_ONE;
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      head_d = head_q + PTR_ONE;
    end else begin
      head_d = head_q;
    end
    case ({push_s, pop_s})
      2'b10:   size_d = size_q + SZ_ONE;
      2'b01:   size_d = size_q - SZ_ONE;
      default: size_d = size_q;
    endcase
    if (we && full_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // FIFO control registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head_q     <= '0;
      tail_q     <= '0;
      size_q     <= SZ_ZERO;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      size_q     <= size_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents need no reset because size gates every read.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q[tail_q] <= wd;
    end
  end

  // Serializer: pop a word, then pulse tx_start once per byte.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      word_q     <= 32'h0000_0000;
      k_q        <= 2'd0;
      tx_start_q <= 1'b0;
      sdata_q    <= 8'h00;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop_s) begin
            word_q  <= mem_q[head_q];
            k_q     <= 2'd0;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!tx_busy) begin
            tx_start_q <= 1'b1;
            sdata_q    <= pick_byte(word_q, k_q);
            state_q    <= ST_GUARD;
          end
        end
        // One dead cycle so UartTx's registered busy is visible in WAIT.
        ST_GUARD: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!tx_busy) begin
            if (k_q == 2'd3) begin
              state_q <= ST_IDLE;
            end else begin
              k_q     <= k_q + 2'd1;
              state_q <= ST_SEND;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign full     = full_s;
  assign size     = size_q;
  assign overflow = overflow_q;
  assign tx_start = tx_start_q;
  assign sdata    = sdata_q;
  assign idle     = (state_q == ST_IDLE) && (size_q == SZ_ZERO);

endmodule
